// File: rtl/kseq_pkg.sv
// Shared definitions for the kernel BRAM sequencer: FSM state encoding and
// default parameter values.
package kseq_pkg;
  localparam int KSEQ_RD_LATENCY = 2;
  localparam int KSEQ_FILTER_W   = 10;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_IDLE  = 3'd1,
    S_LOAD       = 3'd2,
    S_WAIT_IDLE2 = 3'd3,
    S_FETCH      = 3'd4,
    S_LAT        = 3'd5,
    S_PRESENT    = 3'd6
  } kseq_state_t;
endpackage

// File: rtl/kseq_counter.sv
// Generic up-counter with synchronous clear (priority) and count enable.
module kseq_counter #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)   q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= q + 1'b1;
endmodule

// File: rtl/kernel_bram_sequencer.sv
// Per-filter kernel BRAM sequencer: load one kernel, then step the read port
// channel by channel under a valid/ready handshake with the MAC array.
// Optional perf counters (stall_cycles, load_cycles) with KSEQ_PERF_CNT_EN.
module kernel_bram_sequencer
  import kseq_pkg::*;
#(
  parameter int RD_LATENCY = KSEQ_RD_LATENCY,
  parameter int FILTER_W   = KSEQ_FILTER_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [FILTER_W-1:0] num_filters,
  input  logic                last_loading_1ker,
  input  logic                last_channel,
  input  logic                Kernel_BRAM_IDLE,
  output logic                load_BRAM_dina,
  output logic                update_BRAM_doutb,
  output logic                ker_valid,
  input  logic                ker_ready,
  output logic                ker_last,
  output logic [FILTER_W-1:0] filter_idx,
  output logic                busy,
  output logic                done
`ifdef KSEQ_PERF_CNT_EN
  ,
  output logic [31:0]         stall_cycles,
  output logic [31:0]         load_cycles
`endif
);
  localparam int LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  kseq_state_t         state, state_nxt;
  logic [FILTER_W-1:0] nf;
  logic                ker_last_pending;
  logic [LAT_W-1:0]    lat_cnt;
  logic                start_acc, final_f, last_hs;

  assign start_acc = (state == S_IDLE) && start;
  assign final_f   = (filter_idx == nf - 1'b1);
  assign last_hs   = (state == S_PRESENT) && ker_ready && ker_last_pending;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state            <= S_IDLE;
      nf               <= '0;
      ker_last_pending <= 1'b0;
      lat_cnt          <= '0;
    end else begin
      state <= state_nxt;
      if (start_acc)
        nf <= (num_filters == '0) ? FILTER_W'(1) : num_filters;
      if (state == S_FETCH) begin
        ker_last_pending <= last_channel;
        lat_cnt          <= LAT_W'(RD_LATENCY - 1);
      end else if (state == S_LAT && lat_cnt != '0) begin
        lat_cnt <= lat_cnt - 1'b1;
      end
    end

  always_comb begin
    state_nxt         = state;
    load_BRAM_dina    = 1'b0;
    update_BRAM_doutb = 1'b0;
    ker_valid         = 1'b0;
    ker_last          = 1'b0;
    done              = 1'b0;
    busy              = (state != S_IDLE);
    case (state)
      S_IDLE:       if (start) state_nxt = S_WAIT_IDLE;
      S_WAIT_IDLE:  if (Kernel_BRAM_IDLE) state_nxt = S_LOAD;
      S_LOAD: begin
        load_BRAM_dina = 1'b1;
        if (last_loading_1ker) state_nxt = S_WAIT_IDLE2;
      end
      S_WAIT_IDLE2: if (Kernel_BRAM_IDLE) state_nxt = S_FETCH;
      S_FETCH: begin
        update_BRAM_doutb = 1'b1;
        state_nxt         = S_LAT;
      end
      S_LAT:        if (lat_cnt == '0) state_nxt = S_PRESENT;
      S_PRESENT: begin
        ker_valid = 1'b1;
        ker_last  = ker_last_pending;
        if (ker_ready) begin
          if (!ker_last_pending) state_nxt = S_FETCH;
          else if (final_f) begin
            done      = 1'b1;
            state_nxt = S_IDLE;
          end else state_nxt = S_WAIT_IDLE;
        end
      end
      default:      state_nxt = S_IDLE;
    endcase
  end

  // Filter index advances only between filters; the final handshake leaves it at nf-1.
  kseq_counter #(.W(FILTER_W)) u_filter_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_acc),
    .en    (last_hs && !final_f),
    .q     (filter_idx)
  );

`ifdef KSEQ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stall_cycles <= '0;
      load_cycles  <= '0;
    end else if (start_acc) begin
      stall_cycles <= '0;
      load_cycles  <= '0;
    end else begin
      if (state == S_PRESENT && !ker_ready && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
      if (state == S_LOAD && load_cycles != '1)
        load_cycles <= load_cycles + 1'b1;
    end
`endif
endmodule

// File: tb/tb_kernel_bram_sequencer.sv
// Randomized bench for kernel_bram_sequencer with an event-level reference model
// of the load/fetch/present protocol and a behavioural kernel BRAM.
module tb_kernel_bram_sequencer;
  localparam int RD_LAT = 2;
  localparam int FW     = 10;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [FW-1:0] num_filters = '0;
  logic          last_loading_1ker = 1'b0, last_channel = 1'b0;
  logic          Kernel_BRAM_IDLE = 1'b0, ker_ready = 1'b0;
  logic          load_BRAM_dina, update_BRAM_doutb, ker_valid, ker_last, busy, done;
  logic [FW-1:0] filter_idx;
`ifdef KSEQ_PERF_CNT_EN
  logic [31:0]   stall_cycles, load_cycles;
`endif

  kernel_bram_sequencer #(.RD_LATENCY(RD_LAT), .FILTER_W(FW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_filters(num_filters),
    .last_loading_1ker(last_loading_1ker), .last_channel(last_channel),
    .Kernel_BRAM_IDLE(Kernel_BRAM_IDLE), .load_BRAM_dina(load_BRAM_dina),
    .update_BRAM_doutb(update_BRAM_doutb), .ker_valid(ker_valid),
    .ker_ready(ker_ready), .ker_last(ker_last), .filter_idx(filter_idx),
    .busy(busy), .done(done)
`ifdef KSEQ_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .load_cycles(load_cycles)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int ch_size = 3, load_len = 2;
  int idle_mode = 0, ready_mode = 0;  // 0: bench BRAM/MAC drive randomly, else main drives

  // reference model state
  bit m_busy, e_dina, e_upd, e_valid;
  int m_nf, m_f, m_ch, m_wait, m_lat;
  int n_loads, n_upd, n_hs, n_done;
  bit prev_dina;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // behavioural kernel BRAM + random MAC backpressure
  initial begin
    int lcnt, useen;
    bit pupd;
    lcnt = 0; useen = 0; pupd = 0;
    forever begin
      @(posedge clk); #1;
      lcnt = load_BRAM_dina ? lcnt + 1 : 0;
      if (pupd) useen++;
      if (load_BRAM_dina) useen = 0;
      pupd = update_BRAM_doutb;
      last_loading_1ker = load_BRAM_dina ? (lcnt >= load_len) : ($urandom_range(4) == 0);
      last_channel = (useen == ch_size - 1);
      if (idle_mode == 0) Kernel_BRAM_IDLE = !load_BRAM_dina && ($urandom_range(3) != 0);
      if (ready_mode == 0) ker_ready = ($urandom_range(9) < 7);
    end
  end

  // per-cycle compare against the protocol model
  initial begin
    bit hs, e_done, n_busy, n_dina, n_updb, n_valid;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_busy = 0; e_dina = 0; e_upd = 0; e_valid = 0;
        m_nf = 0; m_f = 0; m_ch = 0; m_wait = 0; m_lat = 0; prev_dina = 0;
        continue;
      end
      hs     = e_valid && ker_ready;
      e_done = hs && (m_ch == ch_size - 1) && (m_f == m_nf - 1);
      chk("cycle", {busy, load_BRAM_dina, update_BRAM_doutb, ker_valid, ker_last, done, filter_idx},
                   {m_busy, e_dina, e_upd, e_valid, e_valid && (m_ch == ch_size - 1), e_done, FW'(m_f)});
      if (load_BRAM_dina && !prev_dina) n_loads++;
      prev_dina = load_BRAM_dina;
      if (update_BRAM_doutb) n_upd++;
      if (ker_valid && ker_ready) n_hs++;
      if (done) n_done++;

      n_busy = m_busy; n_dina = e_dina; n_updb = 0; n_valid = e_valid;
      if (!m_busy) begin
        if (start) begin
          n_busy = 1; m_nf = (num_filters == 0) ? 1 : int'(num_filters);
          m_f = 0; m_ch = 0; m_wait = 1;
        end
      end else begin
        if (m_wait == 1 && Kernel_BRAM_IDLE) begin n_dina = 1; m_wait = 0; end
        else if (m_wait == 2 && Kernel_BRAM_IDLE) begin n_updb = 1; m_wait = 0; end
        if (e_dina && last_loading_1ker) begin n_dina = 0; m_wait = 2; end
        if (m_lat > 0) begin m_lat--; if (m_lat == 0) n_valid = 1; end
        if (e_upd) m_lat = RD_LAT;
        if (hs) begin
          n_valid = 0;
          if (m_ch < ch_size - 1) begin m_ch++; n_updb = 1; end
          else if (m_f == m_nf - 1) n_busy = 0;
          else begin m_f++; m_ch = 0; m_wait = 1; end
        end
      end
      m_busy = n_busy; e_dina = n_dina; e_upd = n_updb; e_valid = n_valid;
    end
  end

  task automatic run(input int nf, input int ch, input int ll);
    num_filters = FW'(nf); ch_size = ch; load_len = ll;
    n_loads = 0; n_upd = 0; n_hs = 0; n_done = 0;
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int c = 0;
    while (n_done == 0 && c < budget) begin tick(); c++; end
    chk({name, "_done_seen"}, 64'(n_done != 0), 64'(1));
    tick(2);
  endtask

  task automatic wait_sig(input bit valid_not_dina, input string name);
    int c = 0;
    while (!(valid_not_dina ? ker_valid : load_BRAM_dina) && c < 500) begin tick(); c++; end
    chk(name, 64'(c < 500), 64'(1));
  endtask

  initial begin
    int u;
    #1;
    chk("reset_outputs", {busy, load_BRAM_dina, update_BRAM_doutb, ker_valid, ker_last, done, filter_idx}, '0);
    tick(2); rst_n = 1'b1; tick(2);

    // single filter, 3 channels, MAC always ready
    ready_mode = 1; ker_ready = 1'b1;
    run(1, 3, 3);
    wait_done("f1", 2000);
    chk("f1_loads", n_loads, 1); chk("f1_upd", n_upd, 3);
    chk("f1_hs", n_hs, 3);       chk("f1_done", n_done, 1);
`ifdef KSEQ_PERF_CNT_EN
    chk("f1_load_cycles", load_cycles, 3);
`endif

    // four filters, 2 channels
    run(4, 2, 2);
    wait_done("f4", 3000);
    chk("f4_loads", n_loads, 4); chk("f4_upd", n_upd, 8);
    chk("f4_hs", n_hs, 8);       chk("f4_done", n_done, 1);
    chk("f4_last_idx", filter_idx, 3);

    // MAC stalls 10 cycles on the first kernel
    ready_mode = 2; ker_ready = 1'b0;
    run(2, 2, 1);
    wait_sig(1'b1, "stall_valid_seen");
    u = n_upd;
    tick(10);
    chk("stall_valid_held", ker_valid, 1);
    chk("stall_idx", filter_idx, 0);
    chk("stall_no_upd", n_upd, u);
`ifdef KSEQ_PERF_CNT_EN
    chk("stall_cycles", stall_cycles, 10);
`endif
    ready_mode = 0;
    wait_done("stall", 3000);
    chk("stall_hs", n_hs, 4);

    // kernel BRAM busy for 5 cycles after start
    idle_mode = 2; Kernel_BRAM_IDLE = 1'b0;
    run(1, 2, 2);
    for (int i = 0; i < 5; i++) begin
      chk("idle_low_no_load", load_BRAM_dina, 0);
      tick();
    end
    Kernel_BRAM_IDLE = 1'b1;
    tick();
    chk("load_after_idle", load_BRAM_dina, 1);
    idle_mode = 0;
    wait_done("idle", 2000);
    chk("idle_hs", n_hs, 2);

    // num_filters=0 acts as 1; a start while busy is ignored
    run(0, 3, 2);
    wait_sig(1'b0, "nf0_load_seen");
    start = 1'b1; tick(); start = 1'b0;
    wait_done("nf0", 2000);
    chk("nf0_loads", n_loads, 1); chk("nf0_hs", n_hs, 3); chk("nf0_done", n_done, 1);
    tick(10);
    chk("nf0_idle_after", busy, 0);

    // randomized runs
    for (int r = 0; r < 6; r++) begin
      int nf, ch;
      nf = $urandom_range(1, 4); ch = $urandom_range(1, 4);
      run(nf, ch, $urandom_range(1, 4));
      wait_done("rand", 4000);
      chk("rand_hs", n_hs, nf * ch);
      chk("rand_loads", n_loads, nf);
      chk("rand_done", n_done, 1);
    end

    // reset in the middle of a load
    idle_mode = 1; Kernel_BRAM_IDLE = 1'b1;
    run(2, 2, 100000);
    wait_sig(1'b0, "rst_load_seen");
    @(posedge clk); #3;
    rst_n = 1'b0; #1;
    chk("rst_mid_load", {busy, load_BRAM_dina, update_BRAM_doutb, ker_valid, ker_last, done, filter_idx}, '0);
    tick(2);
    @(posedge clk); #3; rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_idle", busy, 0);
    tick(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
